// File: rtl/usb_tx_pkg.sv
// Shared definitions for the USB full-speed transmit back end: line-state codes,
// bus line levels and default timing/stuffing parameters.
package usb_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SYNC   = 3'd1,
    ST_PID    = 3'd2,
    ST_DATA   = 3'd3,
    ST_CRC_HI = 3'd4,
    ST_CRC_LO = 3'd5,
    ST_EOP1   = 3'd6,
    ST_EOP2   = 3'd7
  } line_state_e;

  // {dplus, dminus}
  localparam logic [1:0] LINE_J   = 2'b10;
  localparam logic [1:0] LINE_K   = 2'b01;
  localparam logic [1:0] LINE_SE0 = 2'b00;

  localparam int DEF_BIT_CLKS   = 8;
  localparam int DEF_LONG_EVERY = 3;
  localparam int DEF_STUFF_LEN  = 6;

  // States in which serial bits are driven onto the bus
  function automatic logic is_packet_state(input line_state_e s);
    return (s >= ST_SYNC) && (s <= ST_CRC_LO);
  endfunction

  // States carrying controller-supplied payload (data and CRC)
  function automatic logic is_payload_state(input line_state_e s);
    return (s >= ST_DATA) && (s <= ST_CRC_LO);
  endfunction

  function automatic logic [1:0] line_of_level(input logic level);
    return level ? LINE_J : LINE_K;
  endfunction

endpackage

// File: rtl/usb_bit_timer.sv
// Bit-period timer: BIT_CLKS clocks per bit, with every LONG_EVERY-th period
// stretched by one clock; shift_strobe marks the last clock of each period.
module usb_bit_timer #(
  parameter int BIT_CLKS   = 8,
  parameter int LONG_EVERY = 3
) (
  input  logic clk,
  input  logic n_rst,
  input  logic enable_timer,
  input  logic clear_timer,
  output logic shift_strobe
);

  localparam int CNT_W = $clog2(BIT_CLKS + 1);
  localparam logic [1:0]       LAST_PHASE = 2'(LONG_EVERY - 1);
  localparam logic [CNT_W-1:0] SHORT_LAST = CNT_W'(BIT_CLKS - 1);
  localparam logic [CNT_W-1:0] LONG_LAST  = CNT_W'(BIT_CLKS);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] last_cnt;
  logic [1:0]       phase;
  logic             wrap;

  always_comb begin
    last_cnt     = (phase == LAST_PHASE) ? LONG_LAST : SHORT_LAST;
    wrap         = (cnt == last_cnt);
    shift_strobe = wrap && enable_timer && !clear_timer;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt   <= '0;
      phase <= '0;
    end else if (clear_timer) begin
      cnt   <= '0;
      phase <= '0;
    end else if (enable_timer) begin
      if (wrap) begin
        cnt   <= '0;
        phase <= (phase == LAST_PHASE) ? 2'd0 : phase + 2'd1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/usb_tx_encoder.sv
// USB full-speed TX back end: LSB-first serialiser, bit stuffer, NRZI encoder and EOP.
// Optional build macro USB_TX_UNDERRUN_EN adds the sticky tx_underrun output.
module usb_tx_encoder
  import usb_tx_pkg::*;
#(
  parameter int BIT_CLKS   = DEF_BIT_CLKS,
  parameter int LONG_EVERY = DEF_LONG_EVERY,
  parameter int STUFF_LEN  = DEF_STUFF_LEN
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic [2:0] state_val,
  input  logic       load_enable,
  input  logic [7:0] data_pts,
  input  logic       enable_timer,
  input  logic       clear_timer,
  output logic       shift_strobe,
  output logic       flag,
  output logic       dplus,
  output logic       dminus
`ifdef USB_TX_UNDERRUN_EN
  ,
  output logic       tx_underrun
`endif
);

  localparam int ONES_W = $clog2(STUFF_LEN + 1);
  localparam logic [ONES_W-1:0] ONES_MAX = ONES_W'(STUFF_LEN);

  line_state_e       line_state;
  line_state_e       prev_state;
  logic [7:0]        hold_reg;
  logic              hold_valid;
  logic [7:0]        sr;
  logic              sr_full;
  logic [3:0]        bit_cnt;
  logic [ONES_W-1:0] ones_cnt;
  logic              nrzi_level;

  logic packet_state;
  logic idle_entry;
  logic empty_load;
  logic shift_evt;
  logic stuff;
  logic normal;
  logic boundary;
  logic tx_bit;
  logic new_level;

  assign line_state = line_state_e'(state_val);

  usb_bit_timer #(
    .BIT_CLKS  (BIT_CLKS),
    .LONG_EVERY(LONG_EVERY)
  ) u_bit_timer (
    .clk         (clk),
    .n_rst       (n_rst),
    .enable_timer(enable_timer),
    .clear_timer (clear_timer),
    .shift_strobe(shift_strobe)
  );

  // An empty shifter is primed first; a strobe in that same cycle is not used.
  always_comb begin
    packet_state = is_packet_state(line_state);
    idle_entry   = (line_state == ST_IDLE) && (prev_state != ST_IDLE);
    empty_load   = !sr_full && (bit_cnt == 4'd0) && hold_valid && !idle_entry;
    shift_evt    = shift_strobe && packet_state && !empty_load;
    stuff        = shift_evt && (ones_cnt == ONES_MAX);
    normal       = shift_evt && !stuff;
    boundary     = normal && (bit_cnt == 4'd7);
    tx_bit       = stuff ? 1'b0 : sr[0];
    new_level    = tx_bit ? nrzi_level : ~nrzi_level;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      prev_state <= ST_IDLE;
      hold_reg   <= 8'h00;
      hold_valid <= 1'b0;
      sr         <= 8'h00;
      sr_full    <= 1'b0;
      bit_cnt    <= 4'd0;
      ones_cnt   <= '0;
      nrzi_level <= 1'b1;
      flag       <= 1'b0;
    end else begin
      prev_state <= line_state;
      flag       <= 1'b0;
      if (load_enable) begin
        hold_reg   <= data_pts;
        hold_valid <= 1'b1;
      end
      if (idle_entry) begin
        ones_cnt   <= '0;
        bit_cnt    <= 4'd0;
        hold_valid <= 1'b0;
        nrzi_level <= 1'b1;
        sr_full    <= 1'b0;
      end else if (empty_load) begin
        sr         <= hold_reg;
        sr_full    <= 1'b1;
        hold_valid <= load_enable;
      end else if (stuff) begin
        nrzi_level <= ~nrzi_level;
        ones_cnt   <= '0;
      end else if (normal) begin
        nrzi_level <= new_level;
        ones_cnt   <= tx_bit ? ones_cnt + 1'b1 : '0;
        if (boundary) begin
          bit_cnt    <= 4'd0;
          flag       <= 1'b1;
          hold_valid <= 1'b0;
          // Same-cycle write bypasses the holding register; nothing pending sends 0x00
          if (load_enable)     sr <= data_pts;
          else if (hold_valid) sr <= hold_reg;
          else                 sr <= 8'h00;
        end else begin
          bit_cnt <= bit_cnt + 4'd1;
          sr      <= {1'b0, sr[7:1]};
        end
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      {dplus, dminus} <= LINE_J;
    end else if (line_state == ST_IDLE) begin
      {dplus, dminus} <= LINE_J;
    end else if (shift_evt) begin
      {dplus, dminus} <= line_of_level(new_level);
    end else if (shift_strobe && !packet_state) begin
      {dplus, dminus} <= LINE_SE0;
    end
  end

`ifdef USB_TX_UNDERRUN_EN
  logic underrun_evt;

  assign underrun_evt = boundary && is_payload_state(line_state) && !hold_valid && !load_enable;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      tx_underrun <= 1'b0;
    end else if (idle_entry) begin
      tx_underrun <= 1'b0;
    end else if (underrun_evt) begin
      tx_underrun <= 1'b1;
    end
  end
`endif

endmodule

// File: doc/usb_tx_encoder.md
Name: usb_tx_encoder

Overview:
Bit-level USB full-speed transmit back end. It sits directly downstream of the TX packet controller, which supplies bytes, a line-state code and timer controls. The block serialises bytes LSB-first, inserts stuffed bits, NRZI-encodes the result onto dplus/dminus and generates EOP. It returns a per-bit shift_strobe and a per-byte flag to the controller.

Parameters:
BIT_CLKS, 8, base clocks per bit period
LONG_EVERY, 3, every LONG_EVERY-th bit period lasts BIT_CLKS+1 clocks (25 clocks / 3 bits at defaults)
STUFF_LEN, 6, consecutive ones before a stuffed zero

Ports:
clk  in  1  system clock
n_rst  in  1  asynchronous active-low reset
state_val  in  3  line code: 0 idle, 1 sync, 2 pid, 3 data, 4 crc_hi, 5 crc_lo, 6 eop1, 7 eop2
load_enable  in  1  data_pts valid; write holding register
data_pts  in  8  byte to transmit
enable_timer  in  1  bit timer count enable
clear_timer  in  1  synchronous bit timer clear (priority over enable)
shift_strobe  out  1  one-cycle pulse on the last clock of each bit period
flag  out  1  one-cycle pulse after the 8th data bit of a byte
dplus  out  1  D+ line
dminus  out  1  D- line

Behaviour:
- Reset: all outputs and internal state are asynchronously reset by n_rst (active-low) on clk. Reset values: dplus=1, dminus=0 (J), shift_strobe=0, flag=0, counters 0, hold_valid=0, shift register 0x00, nrzi_level=J.
- Bit timer: counter cnt and 2-bit phase. When clear_timer=1, cnt=0 and phase=0. Otherwise, when enable_timer=1, cnt increments up to limit-1 and then wraps. limit is BIT_CLKS+1 when phase==LONG_EVERY-1, else BIT_CLKS. phase advances on each wrap. shift_strobe is a combinational decode of cnt==limit-1 && enable_timer && !clear_timer.
- Holding register: every cycle with load_enable=1 captures data_pts (last write wins) and sets hold_valid.
- Shift register load: happens when bit_cnt==0 and the shifter is empty, and at every byte boundary. The shifter takes the holding register and clears hold_valid. If hold_valid=0 at a boundary, the shifter loads 0x00.
- On shift_strobe with state_val in 1..5, one of two actions occurs:
  - Stuff: if ones_cnt==STUFF_LEN, transmit a 0 (toggle nrzi_level), set ones_cnt=0, no shift, bit_cnt unchanged.
  - Normal: transmit sr[0]. A 0 toggles nrzi_level; a 1 holds it. Shift right, bit_cnt++. ones_cnt becomes ones_cnt+1 if the bit was 1, else 0. When bit_cnt reaches 8: bit_cnt=0, register flag=1 for exactly one cycle, reload from the holding register.
- ones_cnt persists across byte boundaries within a packet.
- Line outputs are registered on the strobe edge:
  - state 1..5: dplus=nrzi_level, dminus=~nrzi_level.
  - state 6 or 7: SE0 (0,0) on the next strobe.
  - state 0: J immediately (next edge).
- Entering state 0: ones_cnt=0, bit_cnt=0, hold_valid=0, nrzi_level=J. The timer is untouched and remains controlled by clear_timer.
- Simultaneous load_enable and byte boundary in the same cycle: the boundary reload uses data_pts directly (bypass).
- Mid-packet reset: outputs return to J immediately, asynchronously.

Optional Feature:
USB_TX_UNDERRUN_EN:
- When defined: adds output tx_underrun (1 bit, sticky). It is set when a byte boundary occurs in state_val 3..5 with hold_valid=0 and no bypass load. It is cleared on entry to state 0 and reset to 0.
- When undefined: the port and logic are absent. Underrun silently transmits 0x00.

Decomposition:
- Package usb_tx_pkg:
  - enum for state_val encodings
  - line constants J=2'b10, K=2'b01, SE0=2'b00
  - default BIT_CLKS, LONG_EVERY, STUFF_LEN
- Sub-module usb_bit_timer: cnt/phase counter producing shift_strobe. Parameters are BIT_CLKS and LONG_EVERY; inputs are enable_timer and clear_timer.

Test Plan:
- Timer cadence: enable_timer=1, clear_timer=0 for 100 clocks -> strobe spacing 8,8,9 repeating, i.e. 12 strobes per 100 clocks. clear_timer pulse -> phase restarts at 8.
- Sync: load 0x80, state_val=1 -> line sequence K J K J K J K K over 8 strobes. flag pulses once, one cycle after the 8th strobe.
- Bit stuffing: state 3, load 0xFF twice, starting from ones_cnt=0 -> a stuffed K/J toggle after the 6th one; first flag after 9 strobes. The second byte contains a stuff after its 4th bit.
- EOP: state_val 6 then 7, one strobe each -> dplus/dminus = 00 for two bit periods. state_val 0 -> 10 on the next clock.
- Underrun (with USB_TX_UNDERRUN_EN): state 3, no load_enable at a boundary -> tx_underrun=1, eight strobes transmit 0x00 (eight toggles). Returning to state 0 clears it.
- Reset mid-byte: assert n_rst low during state 3 bit 4 -> dplus=1, dminus=0, flag=0 immediately. After release, first flag only after a full new byte.
